// File: rtl/fsmc_nand_ctrl_if.sv
// fsmc_nand_ctrl_if: FSMC NAND-style pins plus page buffer and backend handshake.
interface fsmc_nand_ctrl_if #(
    parameter int unsigned FSMC_WIDTH = 16,
    parameter int unsigned COL_W      = 4,
    parameter int unsigned ROW_W      = 16
);
    // Host-side FSMC pins
    logic                  CLE;
    logic                  ALE;
    logic                  NCE;
    logic                  NWE;
    logic                  NRE;
    logic [FSMC_WIDTH-1:0] data_in;
    logic [FSMC_WIDTH-1:0] data_out;
    logic                  data_oe;
    logic                  NWAIT;

    // Page buffer RAM port
    logic [COL_W-1:0]      buf_addr;
    logic [FSMC_WIDTH-1:0] buf_wdata;
    logic                  buf_we;
    logic [FSMC_WIDTH-1:0] buf_rdata;

    // Backend storage engine handshake
    logic [ROW_W-1:0]      row_addr;
    logic                  prog_req;
    logic                  load_req;
    logic                  op_ack;
    logic                  op_fail;

    // Environment side: host MCU, buffer RAM and backend
    modport master (
        output CLE, ALE, NCE, NWE, NRE, data_in, buf_rdata, op_ack, op_fail,
        input  data_out, data_oe, NWAIT, buf_addr, buf_wdata, buf_we,
               row_addr, prog_req, load_req
    );

    // Controller side
    modport slave (
        input  CLE, ALE, NCE, NWE, NRE, data_in, buf_rdata, op_ack, op_fail,
        output data_out, data_oe, NWAIT, buf_addr, buf_wdata, buf_we,
               row_addr, prog_req, load_req
    );
endinterface

// File: rtl/fsmc_nand_ctrl.sv
// fsmc_nand_ctrl: decodes the NAND-style FSMC bus, drives the page buffer and
// hands program/load requests to the backend, reporting busy through NWAIT.
module fsmc_nand_ctrl #(
    parameter int unsigned FSMC_WIDTH = 16,
    parameter int unsigned PAGE_WORDS = 16,
    parameter int unsigned COL_W      = 4,
    parameter int unsigned ROW_W      = 16
) (
    input logic             clk,
    input logic             reset,
    fsmc_nand_ctrl_if.slave bus
);

    localparam int unsigned PTR_LAST = PAGE_WORDS - 1;
    localparam int unsigned CTL_W    = 5;
    // {CLE, ALE, NCE, NWE, NRE} with the bus idle and the chip deselected
    localparam logic [CTL_W-1:0] CTL_IDLE = 5'b00111;

    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_PROG_GO = 8'h10;
    localparam logic [7:0] CMD_READ_GO = 8'h30;
    localparam logic [7:0] CMD_STATUS  = 8'h70;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        P_ADDR,
        P_DATA,
        P_BUSY,
        R_ADDR,
        R_CONF,
        R_BUSY,
        R_DATA,
        STATUS
    } state_t;

    logic [CTL_W-1:0]      ctl_raw;
    logic [CTL_W-1:0]      ctl_s1;
    logic [CTL_W-1:0]      ctl_s2;
    logic [FSMC_WIDTH-1:0] din_s1;
    logic [FSMC_WIDTH-1:0] din_s2;
    logic                  nce_q;
    logic                  nwe_q;
    logic                  nre_q;

    logic cle_s;
    logic ale_s;
    logic nce_s;
    logic nwe_s;
    logic nre_s;
    logic we_ev;
    logic re_ev;
    logic nce_rise;
    logic cmd_cyc;
    logic adr_cyc;
    logic dat_cyc;
    logic busy_st;
    logic ready;
    logic [7:0]            cmd;
    logic [COL_W-1:0]      ptr_inc;
    logic [FSMC_WIDTH-1:0] status_word;

    state_t                state;
    state_t                prev_state;
    logic [COL_W-1:0]      ptr;
    logic                  col_done;
    logic                  ce_lost;
    logic [1:0]            rd_pipe;
    logic                  fail;
    logic                  nwait_q;
    logic [FSMC_WIDTH-1:0] data_out_q;
    logic                  buf_we_q;
    logic [COL_W-1:0]      buf_addr_q;
    logic [FSMC_WIDTH-1:0] buf_wdata_q;
    logic [ROW_W-1:0]      row_addr_q;
    logic                  prog_req_q;
    logic                  load_req_q;

    assign ctl_raw = {bus.CLE, bus.ALE, bus.NCE, bus.NWE, bus.NRE};
    assign {cle_s, ale_s, nce_s, nwe_s, nre_s} = ctl_s2;

    // Two-stage synchronizers; data shares the strobe latency so it stays aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_s1 <= CTL_IDLE;
            ctl_s2 <= CTL_IDLE;
            din_s1 <= '0;
            din_s2 <= '0;
            nce_q  <= 1'b1;
            nwe_q  <= 1'b1;
            nre_q  <= 1'b1;
        end else begin
            ctl_s1 <= ctl_raw;
            ctl_s2 <= ctl_s1;
            din_s1 <= bus.data_in;
            din_s2 <= din_s1;
            nce_q  <= nce_s;
            nwe_q  <= nwe_s;
            nre_q  <= nre_s;
        end
    end

    // Strobe edge events, phase decode and helper values
    assign we_ev       = nwe_s & ~nwe_q & ~nce_s;
    assign re_ev       = nre_s & ~nre_q & ~nce_s;
    assign nce_rise    = nce_s & ~nce_q;
    assign cmd_cyc     = cle_s & ~ale_s;
    assign adr_cyc     = ale_s & ~cle_s;
    assign dat_cyc     = ~cle_s & ~ale_s;
    assign cmd         = din_s2[7:0];
    assign ptr_inc     = (ptr == COL_W'(PTR_LAST)) ? '0 : ptr + COL_W'(1);
    assign busy_st     = (state == P_BUSY) || (state == R_BUSY);
    assign ready       = ~(prog_req_q | load_req_q);
    assign status_word = FSMC_WIDTH'({8'h00, 1'b0, ready, 5'b00000, fail});

    // Main sequencer: bus phases, buffer access, backend handshake, registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev_state  <= IDLE;
            ptr         <= '0;
            col_done    <= 1'b0;
            ce_lost     <= 1'b0;
            rd_pipe     <= '0;
            fail        <= 1'b0;
            nwait_q     <= 1'b1;
            data_out_q  <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            row_addr_q  <= '0;
            prog_req_q  <= 1'b0;
            load_req_q  <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            rd_pipe  <= {rd_pipe[0], 1'b0};
            if (rd_pipe[1]) begin
                data_out_q <= bus.buf_rdata;
            end
            if (state == STATUS) begin
                data_out_q <= status_word;
            end

            if (busy_st) begin
                // Host commands are not accepted while the backend owns the page
                if (nce_rise) begin
                    ce_lost <= 1'b1;
                end
                if (bus.op_ack) begin
                    nwait_q    <= 1'b1;
                    prog_req_q <= 1'b0;
                    load_req_q <= 1'b0;
                    ce_lost    <= 1'b0;
                    if (state == P_BUSY) begin
                        fail  <= bus.op_fail;
                        state <= IDLE;
                    end else if (ce_lost || nce_rise) begin
                        state <= IDLE;
                    end else begin
                        state      <= R_DATA;
                        buf_addr_q <= ptr;
                        rd_pipe    <= 2'b01;
                    end
                end
            end else if (nce_rise) begin
                state <= IDLE;
            end else if (we_ev) begin
                if (cmd_cyc) begin
                    case (cmd)
                        CMD_PROG: begin
                            state    <= P_ADDR;
                            col_done <= 1'b0;
                        end
                        CMD_READ: begin
                            if (state == STATUS && prev_state == R_DATA) begin
                                // Resume the interrupted read stream at the current pointer
                                state      <= R_DATA;
                                buf_addr_q <= ptr;
                                rd_pipe    <= 2'b01;
                            end else begin
                                state    <= R_ADDR;
                                col_done <= 1'b0;
                            end
                        end
                        CMD_STATUS: begin
                            state <= STATUS;
                            if (state != STATUS) begin
                                prev_state <= state;
                            end
                        end
                        CMD_RESET: begin
                            state <= IDLE;
                            fail  <= 1'b0;
                        end
                        CMD_PROG_GO: begin
                            if (state == P_DATA) begin
                                state      <= P_BUSY;
                                prog_req_q <= 1'b1;
                                nwait_q    <= 1'b0;
                                ce_lost    <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        CMD_READ_GO: begin
                            if (state == R_CONF) begin
                                state      <= R_BUSY;
                                load_req_q <= 1'b1;
                                nwait_q    <= 1'b0;
                                ce_lost    <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end else if (adr_cyc) begin
                    if (state == P_ADDR || state == R_ADDR) begin
                        if (!col_done) begin
                            ptr      <= COL_W'(din_s2);
                            col_done <= 1'b1;
                        end else begin
                            row_addr_q <= ROW_W'(din_s2);
                            col_done   <= 1'b0;
                            state      <= (state == P_ADDR) ? P_DATA : R_CONF;
                        end
                    end
                end else if (dat_cyc && state == P_DATA) begin
                    buf_we_q    <= 1'b1;
                    buf_addr_q  <= ptr;
                    buf_wdata_q <= din_s2;
                    ptr         <= ptr_inc;
                end
            end else if (re_ev && state == R_DATA) begin
                ptr        <= ptr_inc;
                buf_addr_q <= ptr_inc;
                rd_pipe    <= 2'b01;
            end
        end
    end

    // Output enable follows the raw pins so the bus turns around without sync delay
    assign bus.data_oe   = ((state == R_DATA) || (state == STATUS)) & ~bus.NCE & ~bus.NRE;
    assign bus.data_out  = data_out_q;
    assign bus.NWAIT     = nwait_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.row_addr  = row_addr_q;
    assign bus.prog_req  = prog_req_q;
    assign bus.load_req  = load_req_q;

endmodule

// File: tb/tb_fsmc_nand_ctrl.sv
// tb_fsmc_nand_ctrl: directed bench with a host pin driver, buffer RAM and backend model.
module tb_fsmc_nand_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 16;

    typedef struct {
        logic          cle;
        logic          ale;
        logic [W-1:0]  din;
        logic          exp_we;
        logic [CW-1:0] exp_addr;
        logic [W-1:0]  exp_wd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fsmc_nand_ctrl_if #(.FSMC_WIDTH(W), .COL_W(CW), .ROW_W(RW)) bus ();

    fsmc_nand_ctrl #(
        .FSMC_WIDTH(W),
        .PAGE_WORDS(16),
        .COL_W(CW),
        .ROW_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // Page buffer RAM with one-cycle read latency
    logic [W-1:0] mem [16];
    always @(posedge clk) begin
        if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdata;
        bus.buf_rdata <= mem[bus.buf_addr];
    end

    // Buffer write monitor
    int            we_cnt = 0;
    logic [CW-1:0] we_addr;
    logic [W-1:0]  we_data;
    always @(posedge clk) begin
        if (bus.buf_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.buf_addr;
            we_data <= bus.buf_wdata;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic cle, input logic ale, input logic [W-1:0] din,
                       input logic we, input logic [CW-1:0] a, input logic [W-1:0] wd);
        vec_t v;
        v.cle = cle; v.ale = ale; v.din = din;
        v.exp_we = we; v.exp_addr = a; v.exp_wd = wd;
        vecs.push_back(v);
    endtask

    task automatic bus_wr(input logic cle, input logic ale, input logic [W-1:0] d);
        @(negedge clk);
        bus.CLE = cle; bus.ALE = ale; bus.data_in = d; bus.NWE = 1'b0;
        repeat (3) @(negedge clk);
        bus.NWE = 1'b1;
        repeat (4) @(negedge clk);
        bus.CLE = 1'b0; bus.ALE = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_pulse(output logic [W-1:0] d, output logic oe);
        @(negedge clk);
        bus.NRE = 1'b0;
        repeat (2) @(negedge clk);
        d  = bus.data_out;
        oe = bus.data_oe;
        bus.NRE = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic apply(input int lo, input int hi);
        int c0;
        for (int i = lo; i < hi; i++) begin
            c0 = we_cnt;
            bus_wr(vecs[i].cle, vecs[i].ale, vecs[i].din);
            check($sformatf("we_count[%0d]", i), 32'(we_cnt - c0), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("we_addr[%0d]", i), 32'(we_addr), 32'(vecs[i].exp_addr));
                check($sformatf("we_data[%0d]", i), 32'(we_data), 32'(vecs[i].exp_wd));
            end
        end
    endtask

    task automatic backend(input bit is_prog, input int lat, input logic fl);
        int t = 0;
        int hi = 0;
        while (((is_prog ? bus.prog_req : bus.load_req) !== 1'b1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(is_prog ? "prog_req_rise" : "load_req_rise", (t < 50) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < lat; i++) begin
            if ((is_prog ? bus.prog_req : bus.load_req) && !bus.NWAIT) hi++;
            @(negedge clk);
        end
        check(is_prog ? "prog_busy_hold" : "load_busy_hold", 32'(hi), 32'(lat));
        bus.op_ack = 1'b1; bus.op_fail = fl;
        @(negedge clk);
        bus.op_ack = 1'b0; bus.op_fail = 1'b0;
        check("req_drop", 32'(is_prog ? bus.prog_req : bus.load_req), 32'd0);
        check("nwait_release", 32'(bus.NWAIT), 32'd1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         oe;
        int           ga, gb, gc, gd, ge, gend, t;

        // Vector table: host bus cycles and the buffer write each should cause
        ga = vecs.size();
        add(1, 0, 16'h80, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 1, 16'h05, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 0, W'(i), 1, CW'(i), W'(i));
        gb = vecs.size();
        add(1, 0, 16'h80, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        for (int i = 0; i < 18; i++) add(0, 0, W'(i), 1, CW'(i % 16), W'(i));
        gc = vecs.size();
        add(0, 1, 16'h07, 0, 0, 0);
        add(0, 0, 16'h77, 0, 0, 0);
        add(1, 0, 16'h10, 0, 0, 0);
        gd = vecs.size();
        add(1, 0, 16'h80, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 0, 16'hA0, 1, 0, 16'hA0);
        add(1, 0, 16'h55, 0, 0, 0);
        add(0, 0, 16'hA1, 0, 0, 0);
        ge = vecs.size();
        add(1, 0, 16'h80, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 1, 16'h00, 0, 0, 0);
        add(0, 0, 16'hB0, 1, 0, 16'hB0);
        add(1, 1, 16'h10, 0, 0, 0);
        add(0, 0, 16'hB1, 1, 1, 16'hB1);
        gend = vecs.size();

        // Reset state
        reset = 1'b1;
        bus.CLE = 0; bus.ALE = 0; bus.NCE = 0; bus.NWE = 1; bus.NRE = 0;
        bus.data_in = '0; bus.op_ack = 0; bus.op_fail = 0;
        repeat (3) @(negedge clk);
        check("rst_nwait", 32'(bus.NWAIT), 1);
        check("rst_data_oe", 32'(bus.data_oe), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_buf_we", 32'(bus.buf_we), 0);
        check("rst_prog_req", 32'(bus.prog_req), 0);
        check("rst_load_req", 32'(bus.load_req), 0);
        check("rst_row_addr", 32'(bus.row_addr), 0);
        check("rst_buf_addr", 32'(bus.buf_addr), 0);
        bus.NRE = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Program a page of 0..15 at row 5
        apply(ga, gb);
        check("prog_row_addr", 32'(bus.row_addr), 32'h5);
        bus_wr(1, 0, 16'h10);
        backend(1'b1, 20, 1'b0);

        // Status after a passing program, then after a failing one, then cleared
        bus_wr(1, 0, 16'h70);
        check("status_oe_nre_high", 32'(bus.data_oe), 0);
        rd_pulse(d, oe);
        check("status_oe", 32'(oe), 1);
        check("status_pass", 32'(d), 32'h0040);
        bus_wr(1, 0, 16'h80); bus_wr(0, 1, 16'h0); bus_wr(0, 1, 16'h5);
        bus_wr(1, 0, 16'h10);
        backend(1'b1, 20, 1'b1);
        bus_wr(1, 0, 16'h70);
        rd_pulse(d, oe);
        check("status_fail", 32'(d), 32'h0041);
        bus_wr(1, 0, 16'hFF);
        bus_wr(1, 0, 16'h70);
        rd_pulse(d, oe);
        check("status_cleared", 32'(d), 32'h0040);

        // Read from column 3 of row 2 with wrap-around
        bus_wr(1, 0, 16'h00); bus_wr(0, 1, 16'h3); bus_wr(0, 1, 16'h2);
        check("read_row_addr", 32'(bus.row_addr), 32'h2);
        bus_wr(1, 0, 16'h30);
        backend(1'b0, 10, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd_pulse(d, oe);
            check($sformatf("read_word[%0d]", i), 32'(d), 32'((3 + i) % 16));
            check($sformatf("read_oe[%0d]", i), 32'(oe), 1);
        end
        // Status interrupts the stream; 0x00 resumes at the same column
        bus_wr(1, 0, 16'h70);
        rd_pulse(d, oe);
        check("status_mid_read", 32'(d), 32'h0040);
        bus_wr(1, 0, 16'h00);
        rd_pulse(d, oe);
        check("resume_word0", 32'(d), 32'h3);
        rd_pulse(d, oe);
        check("resume_word1", 32'(d), 32'h4);

        // Overflow: 18 words wrap onto columns 0 and 1
        bus_wr(1, 0, 16'hFF);
        apply(gb, gc);
        bus_wr(1, 0, 16'hFF);
        bus_wr(1, 0, 16'h00); bus_wr(0, 1, 16'h0); bus_wr(0, 1, 16'h0);
        bus_wr(1, 0, 16'h30);
        backend(1'b0, 5, 1'b0);
        repeat (3) @(negedge clk);
        rd_pulse(d, oe);
        check("overflow_col0", 32'(d), 32'd16);
        rd_pulse(d, oe);
        check("overflow_col1", 32'(d), 32'd17);

        // Abort: chip deselect after one address cycle drops back to IDLE
        bus_wr(1, 0, 16'hFF);
        bus_wr(1, 0, 16'h80);
        bus_wr(0, 1, 16'h1);
        @(negedge clk); bus.NCE = 1'b1;
        repeat (6) @(negedge clk); bus.NCE = 1'b0;
        repeat (3) @(negedge clk);
        apply(gc, gd);
        check("abort_prog_req", 32'(bus.prog_req), 0);
        check("abort_nwait", 32'(bus.NWAIT), 1);

        // Reset asserted while busy clears the request immediately
        bus_wr(1, 0, 16'h80); bus_wr(0, 1, 16'h0); bus_wr(0, 1, 16'h0);
        bus_wr(1, 0, 16'h10);
        t = 0;
        while (bus.prog_req !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("busy_before_reset", 32'(bus.prog_req), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_prog_req", 32'(bus.prog_req), 0);
        check("reset_nwait", 32'(bus.NWAIT), 1);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);

        // Unknown command and CLE+ALE together
        apply(gd, ge);
        apply(ge, gend);
        check("both_high_prog_req", 32'(bus.prog_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
